// File: rtl/button_press_classifier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_pkg
// Purpose  : Shared types for the button press classifier: FSM state encoding
//            and the event codes consumed by the downstream command decoder.
// Revision : 1.0 - initial release
// ============================================================================
package button_pkg;

    // Gesture classifier states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_GAP  = 3'd3,
        SECOND    = 3'd4,
        LOCKOUT   = 3'd5
    } state_t;

    // Event codes shared with the command decoder.
    localparam logic [1:0] EVT_NONE   = 2'd0;
    localparam logic [1:0] EVT_SHORT  = 2'd1;
    localparam logic [1:0] EVT_LONG   = 2'd2;
    localparam logic [1:0] EVT_DOUBLE = 2'd3;

    // Collapse the three one-hot pulses into a single event code.
    function automatic logic [1:0] encode_event(input logic i_short,
                                                input logic i_long,
                                                input logic i_double);
        if (i_long)        return EVT_LONG;
        else if (i_double) return EVT_DOUBLE;
        else if (i_short)  return EVT_SHORT;
        else               return EVT_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_press_classifier_if.sv
`default_nettype none
// ============================================================================
// Module   : button_press_classifier_if
// Purpose  : Groups the debounced button level and the classifier outputs.
//   line         - debounced button level (driven by master)
//   pressed      - registered "line is at press level"
//   short_press  - one-cycle pulse, single short press
//   long_press   - one-cycle pulse, press held the long threshold
//   double_press - one-cycle pulse, two short presses within the gap
//   busy         - classifier is mid-gesture
// Revision : 1.0 - initial release
// ============================================================================
interface button_press_classifier_if;
    logic line;
    logic pressed;
    logic short_press;
    logic long_press;
    logic double_press;
    logic busy;

    modport master (
        output line,
        input  pressed, short_press, long_press, double_press, busy
    );

    modport slave (
        input  line,
        output pressed, short_press, long_press, double_press, busy
    );
endinterface
`default_nettype wire

// File: rtl/button_press_classifier_press_timer.sv
`default_nettype none
// ============================================================================
// Module   : press_timer
// Purpose  : Saturating sample counter with load-to-one, increment and a
//            terminal flag comparing the value about to be written against
//            the selected threshold.
//   clk, reset    - clock, synchronous active-low reset (count cleared)
//   i_load_one    - next count is 1
//   i_increment   - next count is count + 1 (saturating)
//   i_threshold   - value the terminal flag compares against
//   o_terminal    - the count being loaded/incremented equals i_threshold
// Revision : 1.0 - initial release
// ============================================================================
module press_timer #(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_load_one,
    input  logic                     i_increment,
    input  logic [COUNTER_WIDTH-1:0] i_threshold,
    output logic                     o_terminal
);

    localparam logic [COUNTER_WIDTH-1:0] c_one = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] c_max = '1;

    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] w_inc;

    assign w_inc = (r_count == c_max) ? r_count : r_count + c_one;

    // The flag looks at the value the sample at this edge produces, so the
    // FSM can act on the threshold-reaching sample in the same edge.
    assign o_terminal = i_load_one ? (c_one == i_threshold)
                                   : (w_inc == i_threshold);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load_one) begin
            r_count <= c_one;
        end else if (i_increment) begin
            r_count <= w_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_press_classifier.sv
`default_nettype none
// ============================================================================
// Module   : button_press_classifier
// Purpose  : Classifies gestures on a debounced button as short, long or
//            double presses and emits a one-cycle pulse for each.
//   clk   - system clock
//   reset - synchronous, active-low reset
//   btn   - button_press_classifier_if.slave: line in; pressed,
//           short_press, long_press, double_press, busy out (all registered)
// Revision : 1.0 - initial release
// ============================================================================
module button_press_classifier
    import button_pkg::*;
#(
    parameter logic PRESS_LEVEL       = 1'b0,
    parameter int   LONG_PRESS_CYCLES = 1000,
    parameter int   DOUBLE_GAP_CYCLES = 500,
    parameter int   COUNTER_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    button_press_classifier_if.slave  btn
);

    localparam logic [COUNTER_WIDTH-1:0] c_long = COUNTER_WIDTH'(LONG_PRESS_CYCLES);
    localparam logic [COUNTER_WIDTH-1:0] c_gap  = COUNTER_WIDTH'(DOUBLE_GAP_CYCLES);

    state_t                   r_state;
    logic                     r_armed;
    logic                     r_pressed;
    logic                     r_short;
    logic                     r_long;
    logic                     r_double;
    logic                     r_busy;

    logic                     w_p;
    logic                     w_load_one;
    logic                     w_increment;
    logic                     w_terminal;
    logic [COUNTER_WIDTH-1:0] w_threshold;

    assign w_p = (btn.line == PRESS_LEVEL);

    // Timer control. Leaving PRESSED on a release loads the gap count, so the
    // gap threshold is selected there as well as in WAIT_GAP.
    always_comb begin
        w_load_one  = 1'b0;
        w_increment = 1'b0;
        w_threshold = c_long;
        case (r_state)
            IDLE: begin
                w_load_one = w_p;
            end
            PRESSED: begin
                w_increment = w_p;
                w_load_one  = !w_p;
                if (!w_p) begin
                    w_threshold = c_gap;
                end
            end
            WAIT_GAP: begin
                w_load_one  = w_p;
                w_increment = !w_p;
                w_threshold = c_gap;
            end
            SECOND: begin
                w_increment = w_p;
            end
            default: begin
                w_load_one  = 1'b0;
                w_increment = 1'b0;
            end
        endcase
    end

    press_timer #(
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_press_timer (
        .clk         (clk),
        .reset       (reset),
        .i_load_one  (w_load_one),
        .i_increment (w_increment),
        .i_threshold (w_threshold),
        .o_terminal  (w_terminal)
    );

    always_ff @(posedge clk) begin
        r_pressed <= w_p;
    end

    // r_armed is clear only for the first sample after reset; a press seen
    // there was held through reset and is locked out rather than classified.
    // Level changes are tested before thresholds so a sample that does both
    // follows the level change.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_armed  <= 1'b0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_armed  <= 1'b1;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_p) begin
                        r_state <= r_armed ? PRESSED : LOCKOUT;
                        r_busy  <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (w_p) begin
                        if (w_terminal) begin
                            r_long  <= 1'b1;
                            r_state <= LONG_HELD;
                        end
                    end else if (w_terminal) begin
                        // single-sample gap window: the release itself ends it
                        r_short <= 1'b1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= WAIT_GAP;
                    end
                end
                WAIT_GAP: begin
                    if (w_p) begin
                        r_state <= SECOND;
                    end else if (w_terminal) begin
                        r_short <= 1'b1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                SECOND: begin
                    if (w_p) begin
                        if (w_terminal) begin
                            r_long  <= 1'b1;
                            r_state <= LONG_HELD;
                        end
                    end else begin
                        r_double <= 1'b1;
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                LONG_HELD, LOCKOUT: begin
                    if (!w_p) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign btn.pressed      = r_pressed;
    assign btn.short_press  = r_short;
    assign btn.long_press   = r_long;
    assign btn.double_press = r_double;
    assign btn.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_button_press_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_press_classifier
// Purpose  : Self-checking bench for button_press_classifier with
//            LONG=8, GAP=4, active-low button. Outputs are packed as
//            {pressed, short_press, long_press, double_press, busy}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_press_classifier;

    localparam logic PRESS_LEVEL = 1'b0;
    localparam int   LONG        = 8;
    localparam int   GAP         = 4;

    logic clk;
    logic reset;

    button_press_classifier_if bif();

    button_press_classifier #(
        .PRESS_LEVEL       (PRESS_LEVEL),
        .LONG_PRESS_CYCLES (LONG),
        .DOUBLE_GAP_CYCLES (GAP),
        .COUNTER_WIDTH     (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp;
    int         n_fail;
    logic [4:0] got;

    // Reference model: tracks run lengths of pressed/released samples and
    // whether a first short press is waiting for a possible second one.
    bit         m_armed;
    bit         m_ignore;
    bit         m_pending;
    int         m_run_p;
    int         m_run_r;
    logic [4:0] m_exp;

    task automatic model_step(input logic l, input logic rstn);
        logic p;
        logic s;
        logic lg;
        logic d;
        p  = (l == PRESS_LEVEL);
        s  = 1'b0;
        lg = 1'b0;
        d  = 1'b0;
        if (!rstn) begin
            m_armed   = 1'b0;
            m_ignore  = 1'b0;
            m_pending = 1'b0;
            m_run_p   = 0;
            m_run_r   = 0;
            m_exp     = {p, 4'b0000};
        end else begin
            if (!m_armed && p) m_ignore = 1'b1;
            m_armed = 1'b1;
            if (p) begin
                m_run_p++;
                if (!m_ignore && m_run_p == LONG) begin
                    lg        = 1'b1;
                    m_ignore  = 1'b1;
                    m_pending = 1'b0;
                end
            end else begin
                if (m_ignore) begin
                    m_ignore = 1'b0;
                end else if (m_run_p > 0) begin
                    if (m_pending) begin
                        d         = 1'b1;
                        m_pending = 1'b0;
                    end else begin
                        m_pending = 1'b1;
                        m_run_r   = 1;
                        if (m_run_r == GAP) begin
                            s         = 1'b1;
                            m_pending = 1'b0;
                        end
                    end
                end else if (m_pending) begin
                    m_run_r++;
                    if (m_run_r == GAP) begin
                        s         = 1'b1;
                        m_pending = 1'b0;
                    end
                end
                m_run_p = 0;
            end
            m_exp = {p, s, lg, d, (m_ignore || m_pending || m_run_p > 0)};
        end
    endtask

    task automatic step(input logic l, input logic rstn);
        bif.line = l;
        reset    = rstn;
        @(posedge clk);
        model_step(l, rstn);
        #1;
        got = {bif.pressed, bif.short_press, bif.long_press,
               bif.double_press, bif.busy};
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [4:0] actual,
                         input logic [4:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (p/s/l/d/busy) at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic run(input string name, input int n, input logic l,
                       input logic rstn, input logic [4:0] expected);
        for (int i = 0; i < n; i++) begin
            step(l, rstn);
            check(name, got, expected);
        end
    endtask

    typedef struct {
        logic       line;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic l, input logic [4:0] e);
        vec_t v;
        v.line = l;
        v.exp  = e;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        bif.line = 1'b1;
        reset    = 1'b0;
        @(negedge clk);

        // Short press, double press, long press.
        add(1, 1'b1, 5'b00000);
        add(3, 1'b0, 5'b10001);
        add(3, 1'b1, 5'b00001);
        add(1, 1'b1, 5'b01000);
        add(1, 1'b1, 5'b00000);
        add(3, 1'b0, 5'b10001);
        add(2, 1'b1, 5'b00001);
        add(3, 1'b0, 5'b10001);
        add(1, 1'b1, 5'b00010);
        add(1, 1'b1, 5'b00000);
        add(7, 1'b0, 5'b10001);
        add(1, 1'b0, 5'b10101);
        add(12, 1'b0, 5'b10001);
        add(2, 1'b1, 5'b00000);

        // Reset state, line released and then pressed.
        run("reset_idle",    2, 1'b1, 1'b0, 5'b00000);
        run("reset_pressed", 1, 1'b0, 1'b0, 5'b10000);
        run("reset_release", 1, 1'b1, 1'b1, 5'b00000);

        foreach (tbl[i]) begin
            step(tbl[i].line, 1'b1);
            check($sformatf("table[%0d]", i), got, tbl[i].exp);
        end

        // Second press lands on the edge that would have closed the gap.
        run("gapA_press",  3, 1'b0, 1'b1, 5'b10001);
        run("gapA_gap",    3, 1'b1, 1'b1, 5'b00001);
        run("gapA_second", 3, 1'b0, 1'b1, 5'b10001);
        run("gapA_double", 1, 1'b1, 1'b1, 5'b00010);
        run("gapA_idle",   1, 1'b1, 1'b1, 5'b00000);

        // Full gap: short, then the next press stands on its own.
        run("gapB_press1", 3, 1'b0, 1'b1, 5'b10001);
        run("gapB_gap1",   3, 1'b1, 1'b1, 5'b00001);
        run("gapB_short1", 1, 1'b1, 1'b1, 5'b01000);
        run("gapB_press2", 3, 1'b0, 1'b1, 5'b10001);
        run("gapB_gap2",   3, 1'b1, 1'b1, 5'b00001);
        run("gapB_short2", 1, 1'b1, 1'b1, 5'b01000);
        run("gapB_idle",   1, 1'b1, 1'b1, 5'b00000);

        // Triple press: double, then a fresh short.
        run("tri_p1",    2, 1'b0, 1'b1, 5'b10001);
        run("tri_g1",    1, 1'b1, 1'b1, 5'b00001);
        run("tri_p2",    2, 1'b0, 1'b1, 5'b10001);
        run("tri_dbl",   1, 1'b1, 1'b1, 5'b00010);
        run("tri_p3",    2, 1'b0, 1'b1, 5'b10001);
        run("tri_g3",    3, 1'b1, 1'b1, 5'b00001);
        run("tri_short", 1, 1'b1, 1'b1, 5'b01000);

        // Second press held long: long wins, double discarded.
        run("sl_p1",   2, 1'b0, 1'b1, 5'b10001);
        run("sl_g1",   1, 1'b1, 1'b1, 5'b00001);
        run("sl_hold", 7, 1'b0, 1'b1, 5'b10001);
        run("sl_long", 1, 1'b0, 1'b1, 5'b10101);
        run("sl_held", 3, 1'b0, 1'b1, 5'b10001);
        run("sl_rel",  2, 1'b1, 1'b1, 5'b00000);

        // Button held through reset: locked out, then normal again.
        run("rsth_in",    3, 1'b0, 1'b0, 5'b10000);
        run("rsth_lock", 30, 1'b0, 1'b1, 5'b10001);
        run("rsth_rel",   1, 1'b1, 1'b1, 5'b00000);
        run("rsth_p",     3, 1'b0, 1'b1, 5'b10001);
        run("rsth_g",     3, 1'b1, 1'b1, 5'b00001);
        run("rsth_short", 1, 1'b1, 1'b1, 5'b01000);

        // Reset in the gap abandons the pending short press.
        run("rstm_p",     3, 1'b0, 1'b1, 5'b10001);
        run("rstm_g",     2, 1'b1, 1'b1, 5'b00001);
        run("rstm_in",    3, 1'b1, 1'b0, 5'b00000);
        run("rstm_after", 6, 1'b1, 1'b1, 5'b00000);

        // Randomised runs against the reference model.
        step(1'b1, 1'b0);
        check("rand_reset", got, m_exp);
        for (int cyc = 0; cyc < 4000; ) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) len = $urandom_range(LONG - 1, LONG + 3);
            else                           len = $urandom_range(1, GAP + 1);
            for (int k = 0; k < len; k++) begin
                logic rstn;
                rstn = ($urandom_range(0, 299) != 0);
                step(lvl, rstn);
                check("rand", got, m_exp);
                check("rand_onehot", {4'b0000, ($countones(got[3:1]) <= 1)}, 5'b00001);
                cyc++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_press_classifier.md
Name: button_press_classifier

Overview:
- Consumes the single-bit output of the upstream debouncer, which is a clean, glitch-free button level.
- Classifies each button gesture as a short press, long press or double press.
- Each classification drives a one-cycle command pulse to the ROM reader control logic (start read, abort/reset session, dump mode).
- Purely sequential; one instance per user button.

Parameters:
- PRESS_LEVEL, 0: line level that means "button pressed" (active-low buttons by default).
- LONG_PRESS_CYCLES, 1000: consecutive pressed samples that qualify as a long press; must be ≥ 2.
- DOUBLE_GAP_CYCLES, 500: maximum released samples between two presses for a double press; must be ≥ 1.
- COUNTER_WIDTH, 32: width of the internal timer; must hold max(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- line  input  1  debounced button level from debouncer
- pressed  output  1  registered copy of (line == PRESS_LEVEL)
- short_press  output  1  one-cycle pulse, single short press
- long_press  output  1  one-cycle pulse, press held LONG_PRESS_CYCLES
- double_press  output  1  one-cycle pulse, two short presses within gap
- busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Clock and reset:
  - reset is synchronous and active-low; clk is the clock.
  - While reset is low: all pulse outputs are 0, busy = 0, timer = 0, pressed = (line == PRESS_LEVEL).
  - On the first cycle after reset deasserts, the state is IDLE if line is released, or LOCKOUT if line is pressed. A button held through reset never produces an event.
- Sample definitions:
  - P = line sampled at PRESS_LEVEL on a clk edge.
  - R = not P.
  - All outputs are registered. A pulse is high for exactly the one cycle after the clock edge at which its deciding sample is taken.
- States:
  - IDLE: on P → PRESSED, timer = 1; otherwise stay.
  - PRESSED: on P, timer + 1. When timer reaches LONG_PRESS_CYCLES (the LONG-th P sample), pulse long_press → LONG_HELD. On R → WAIT_GAP, timer = 1.
  - LONG_HELD: stay while P; on R → IDLE. No further pulses.
  - WAIT_GAP: on R, timer + 1. When timer reaches DOUBLE_GAP_CYCLES, pulse short_press → IDLE. On P before that → SECOND, timer = 1.
  - SECOND: on P, timer + 1. When timer reaches LONG_PRESS_CYCLES, pulse long_press → LONG_HELD; the pending double is discarded. On R, pulse double_press → IDLE.
  - LOCKOUT: wait for R → IDLE; no pulses.
- Pulse exclusivity:
  - At most one of short_press / long_press / double_press is high in any cycle.
  - Exactly one pulse per completed gesture.
- Timer:
  - Saturating at its maximum value, unsigned.
  - Compare is equality against the parameter value zero-extended to COUNTER_WIDTH.
- Same-edge rule: a sample that both completes a threshold and changes level follows the level change. For example, in WAIT_GAP, P on the edge where the timer would reach the gap goes to SECOND; no short_press.
- Reset mid-gesture: abandons the gesture silently (no pulse), then applies the reset rule above.
- A triple press is reported as a double_press followed by classification of the third press as a fresh gesture.

Decomposition:
- Package button_pkg:
  - state enum (IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND, LOCKOUT).
  - event code constants (EVT_NONE, EVT_SHORT, EVT_LONG, EVT_DOUBLE), reused by the downstream command decoder.
- Sub-module press_timer:
  - COUNTER_WIDTH saturating counter with load-1, increment and terminal-compare output.
  - Instantiated once; the FSM selects the threshold (LONG or GAP) per state.

Test Plan (LONG_PRESS_CYCLES=8, DOUBLE_GAP_CYCLES=4, PRESS_LEVEL=0):
- Short press: line low 3 cycles, then high → short_press pulses once on the cycle after the 4th high sample; no other pulse; busy falls the same cycle.
- Long press: line low 20 cycles → long_press pulses once, the cycle after the 8th low sample; nothing on release; busy drops after the first high sample.
- Double press: low 3, high 2, low 3, high → double_press pulses once, the cycle after the first high sample following the second press; short_press never asserts.
- Gap boundary: low 3, high 3, low on the edge where the 4th high would land → SECOND entered, double_press on release. Repeat with high 4 → short_press, then the second press is classified independently.
- Reset while held: line low during and after reset release, held 30 cycles, then released → no pulses at all; the next 3-cycle press yields short_press.
- Reset mid-gesture: reset asserted in WAIT_GAP → no short_press is emitted, busy = 0 during reset, outputs remain 0.
